// File: rtl/mips_trace_pkg.sv
// Shared types and widths for the write-back trace capture path.
//   DEST_W / DATA_W : register-file write port field widths
//   TS_W            : default timestamp width
//   DROP_CNT_W      : width of the saturating drop counter
//   wb_trace_t      : one captured write {cycle, dest, data} at the default timestamp width
package mips_trace_pkg;

  localparam int unsigned DEST_W     = 3;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned TS_W       = 16;
  localparam int unsigned DROP_CNT_W = 8;

  typedef struct packed {
    logic [TS_W-1:0]   cycle;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_trace_t;

  // Width of one stored entry for an arbitrary timestamp width.
  function automatic int unsigned entry_width(input int unsigned ts_width);
    return ts_width + DEST_W + DATA_W;
  endfunction

endpackage

// File: rtl/mips_trace_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
//   clk   : write clock
//   we    : write enable
//   waddr : write slot
//   wdata : write entry
//   raddr : read slot
//   rdata : entry at raddr (combinational)
module mips_trace_fifo_mem import mips_trace_pkg::*; #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = $bits(wb_trace_t)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage carries no reset; the owner gates reads with its own occupancy.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_wb_trace_fifo.sv
// Captures committed register-file writes, time-stamps them and buffers them in a
// first-word-fall-through FIFO drained over a valid/ready handshake.
//   clk, rst          : clock, asynchronous active-low reset
//   capture_en, clear : capture gate, synchronous flush of FIFO and status
//   reg_write_*       : write-back port of the core
//   trace_*           : head entry and handshake toward the consumer
//   fifo_count        : entries held
//   overflow          : sticky, some write was dropped
//   drop_count        : saturating number of dropped writes
module mips_wb_trace_fifo import mips_trace_pkg::*; #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FILTER_R0 = 1,
  parameter int unsigned TS_WIDTH  = TS_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture_en,
  input  logic                     clear,
  input  logic                     reg_write_en,
  input  logic [DEST_W-1:0]        reg_write_dest,
  input  logic [DATA_W-1:0]        reg_write_data,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [DEST_W-1:0]        trace_dest,
  output logic [DATA_W-1:0]        trace_data,
  output logic [TS_WIDTH-1:0]      trace_cycle,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [DROP_CNT_W-1:0]    drop_count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = entry_width(TS_WIDTH);

  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [TS_WIDTH-1:0] cycle_cnt;
  logic [ENTRY_W-1:0]  wr_entry, head_entry;

  logic push_req, pop, full, push_ok, drop, mem_we;

  // Request/accept decode.
  always_comb begin
    push_req = reg_write_en & capture_en &
               ~((FILTER_R0 != 0) && (reg_write_dest == DEST_W'(0)));
    pop      = trace_valid & trace_ready;
    full     = (count == CNT_W'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok  = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
    mem_we   = push_ok & ~clear;
  end

  assign wr_entry = {cycle_cnt, reg_write_dest, reg_write_data};

  // Free-running timestamp; unaffected by clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cycle_cnt <= '0;
    else      cycle_cnt <= cycle_cnt + TS_WIDTH'(1);
  end

  // Pointers, occupancy and drop status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != {DROP_CNT_W{1'b1}}) drop_count <= drop_count + DROP_CNT_W'(1);
      end
    end
  end

  mips_trace_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head_entry)
  );

  // Head fall-through; fields read zero while empty so stale slots never leak out.
  always_comb begin
    trace_valid = (count != CNT_W'(0));
    trace_cycle = '0;
    trace_dest  = '0;
    trace_data  = '0;
    if (trace_valid) {trace_cycle, trace_dest, trace_data} = head_entry;
  end

  assign fifo_count = count;

endmodule
